// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// Holds state encodings, the requester count and the rotating-priority search.
package rr_arbiter4_pkg;

    localparam int unsigned NREQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Rotate req so ptr sits at bit 0, fixed-priority encode, then undo the rotation.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [3:0] rot;
        logic [1:0] pe;
        logic [1:0] k;
        rot = '0;
        pe  = '0;
        for (int i = 0; i < 4; i++) begin
            k      = ptr + 2'(i);
            rot[i] = req[k];
        end
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) pe = 2'(i);
        end
        return pe + ptr;
    endfunction

endpackage

// File: rtl/decoder2x4.sv
// 2-to-4 one-hot decoder for the shared resource's select lines.
module decoder2x4 (
    input  logic [1:0] sel,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        unique case (sel)
            2'd0: y = 4'b0001;
            2'd1: y = 4'b0010;
            2'd2: y = 4'b0100;
            2'd3: y = 4'b1000;
            default: y = 4'b0000;
        endcase
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// The grant is held until the owner drops its request or MAX_HOLD cycles elapse.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic [3:0]      dec;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, ptr_q);
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A release on the limit cycle wins over the timeout.
                if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + 2'd1;
                end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
                    state_d   = ST_IDLE;
                    ptr_d     = idx_q + 2'd1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    decoder2x4 u_dec (
        .sel (idx_q),
        .y   (dec)
    );

    assign busy    = (state_q == ST_GRANT);
    assign gnt     = dec & {NREQ{busy}};
    assign gnt_idx = idx_q;
    assign timeout = timeout_q;

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one resource, selected through a 2-bit index and a 2-to-4 decoder, among four masters. It sits between the requesting units and the shared resource's select lines. It registers a winning index, decodes it to a one-hot grant, and holds the grant until the owner releases it or a hold limit expires. Fairness is rotating-priority, so no requester can starve another.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner may hold the grant (legal range 2..255).
- `CW`, default 8: width of the hold counter; must satisfy 2^CW > MAX_HOLD.

- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req` in 4: request lines. `req[i]` stays high for as long as requester i wants or holds the resource.
- `gnt` out 4: one-hot grant, or all-zero. Registered.
- `gnt_idx` out 2: binary index of the current owner; meaningful only while `busy`=1.
- `busy` out 1: high while a grant is active.
- `timeout` out 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset values: `gnt`=0000, `gnt_idx`=00, `busy`=0, `timeout`=0, priority pointer `ptr`=0, hold count=0, state IDLE.
- **State IDLE:**
  - If any `req` bit is high, select the first set bit scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
  - Load the selected index into `gnt_idx`, clear the hold count, and go to GRANT.
  - If no bit is high, stay in IDLE.
- **State GRANT:** `gnt` = decode(`gnt_idx`) and `busy`=1.
  - If `req[gnt_idx]`=0 (voluntary release): go to IDLE and set `ptr` = `gnt_idx`+1 mod 4.
  - Else if hold count = `MAX_HOLD`-1 (forced release): go to IDLE, set `ptr` = `gnt_idx`+1 mod 4, and pulse `timeout` on the next cycle.
  - Otherwise, increment the hold count.
- Requests from non-owners during GRANT are ignored; they are re-evaluated only in IDLE.
- A requester whose grant was revoked but who keeps `req` high re-competes normally. It has lowest priority in the next arbitration because `ptr` has moved past it.
- Hold-count arithmetic is unsigned, `CW` bits wide, and never wraps, because it is bounded by `MAX_HOLD`-1.
- **Reset mid-grant:** all outputs return to reset values on the edge where `rst`=1, and `ptr` returns to 0. Reset has priority over every other transition.

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge N. Then `gnt`, `gnt_idx`, and `busy` are valid after edge N (one cycle).
- **Release:** `req[owner]` sampled low at edge M. Then `gnt`=0000 and `busy`=0 after edge M.
- **Turnaround:** at least one full cycle with `gnt`=0000 between two successive grants (bus turnaround). A new owner's `gnt` is visible no earlier than after edge M+1.
- **Maximum hold:** `gnt` stays asserted for at most `MAX_HOLD` consecutive cycles. `timeout` is high for exactly the one cycle in which `gnt` first reads 0000 after a forced release.
- **Simultaneous release and timeout** on the same edge is treated as a voluntary release, so `timeout` stays 0.
- **Worst-case wait** for a continuously requesting master: 3 × (`MAX_HOLD`+1) cycles.
- Outputs never glitch between edges. `gnt` is driven from registered `gnt_idx` and `busy` only.

## Structure
- Shared package/include: state encodings `ST_IDLE`=0 and `ST_GRANT`=1, and the requester count constant `NREQ`=4.
- One sub-module: the team's existing `decoder2x4`, instantiated with `gnt_idx` as input. Its four outputs are ANDed with `busy` to form `gnt`.
- The rotating priority search is a combinational function inside `rr_arbiter4`: rotate `req` by `ptr`, apply a fixed-priority encode, then add `ptr` back.

## Test plan
- **Reset then single request:** `rst` for 2 cycles, then `req`=0100. Expect `gnt`=0100 and `gnt_idx`=10 one cycle later. Drop `req`; expect `gnt`=0000 one cycle later and `ptr`=3.
- **Round-robin fairness:** `req`=1111 held, each owner releasing after 2 cycles by dropping its bit for one cycle. Expect grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
- **Timeout:** `MAX_HOLD`=8, `req`=0001 held forever. Expect `gnt`=0001 for exactly 8 cycles, then `gnt`=0000 with `timeout`=1 for one cycle, then `gnt`=0001 again.
- **Timeout with competitor:** `req`=0011, requester 0 never releases. After the timeout, expect the next grant to be 0010, not 0001.
- **Reset mid-grant:** `gnt`=1000 active; assert `rst` for 1 cycle with `req`=1111. Expect all outputs at reset values, then `gnt`=0001 (pointer reset to 0).
- **Release coinciding with timeout:** drop `req[owner]` on the hold-count = `MAX_HOLD`-1 cycle. Expect `gnt`=0000 with `timeout`=0.
